// File: rtl/cksum_ctrl.sv
// IPv4 header-checksum refresh/verify sequencer owning the packet SRAM port.
// Refresh: CLR, RUN, WB, DONE; verify: RUN, DONE; the engine's ready paces RUN, bounded by TIMEOUT.
module cksum_ctrl #(
  parameter int TIMEOUT  = 1024,
  parameter int ADDR_BUS = 32,
  parameter int DATA_BUS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                mode_i,
  input  logic [ADDR_BUS-1:0] hdr_addr_i,
  input  logic [DATA_BUS-1:0] hdr_len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                ok_o,
  output logic                err_o,
  output logic [15:0]         cksum_o,
  output logic                eng_start_o,
  output logic [ADDR_BUS-1:0] eng_addr_o,
  output logic [DATA_BUS-1:0] eng_len_o,
  input  logic                eng_ready_i,
  input  logic [15:0]         eng_val_i,
  input  logic                eng_sram_ce_i,
  input  logic                eng_sram_we_i,
  input  logic [ADDR_BUS-1:0] eng_sram_addr_i,
  input  logic [3:0]          eng_sram_sel_i,
  input  logic [DATA_BUS-1:0] eng_sram_data_i,
  output logic [DATA_BUS-1:0] eng_sram_data_o,
  output logic                sram_ce_o,
  output logic                sram_we_o,
  output logic [ADDR_BUS-1:0] sram_addr_o,
  output logic [3:0]          sram_sel_o,
  output logic [DATA_BUS-1:0] sram_data_o,
  input  logic [DATA_BUS-1:0] sram_data_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_WB, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic                ce;
    logic                we;
    logic [ADDR_BUS-1:0] addr;
    logic [3:0]          sel;
    logic [DATA_BUS-1:0] data;
  } sram_req_t;

  state_t              state_q, state_d;
  logic [ADDR_BUS-1:0] addr_q, addr_d;
  logic [DATA_BUS-1:0] len_q, len_d;
  logic                mode_q, mode_d;
  logic                ok_q, ok_d;
  logic [15:0]         cksum_q, cksum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic                bad_param;
  logic                eng_hit;
  logic                run_expired;
  logic [ADDR_BUS-1:0] cks_byte;
  sram_req_t           ctl_req;
  sram_req_t           eng_req;
  sram_req_t           sram_req;

  assign accept      = (state_q == S_IDLE) && req_i;
  assign eng_hit     = (state_q == S_RUN) && eng_ready_i;
  assign run_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign bad_param   = hdr_addr_i[0]
                     | (hdr_len_i < DATA_BUS'(20))
                     | (hdr_len_i > DATA_BUS'(60))
                     | (|hdr_len_i[1:0]);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      ok_q    <= 1'b0;
      cksum_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      ok_q    <= ok_d;
      cksum_q <= cksum_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (bad_param)   state_d = S_ERR;
          else if (mode_i) state_d = S_RUN;
          else             state_d = S_CLR;
        end
      end
      S_CLR:  state_d = S_RUN;
      S_RUN: begin
        if (eng_ready_i)      state_d = mode_q ? S_DONE : S_WB;
        else if (run_expired) state_d = S_ERR;
      end
      S_WB:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latches, result capture and RUN cycle counter
  always_comb begin
    addr_d  = accept ? hdr_addr_i : addr_q;
    len_d   = accept ? hdr_len_i  : len_q;
    mode_d  = accept ? mode_i     : mode_q;
    cksum_d = cksum_q;
    ok_d    = ok_q;
    if (accept) begin
      cksum_d = '0;
      ok_d    = 1'b0;
    end else if (eng_hit) begin
      cksum_d = eng_val_i;
      ok_d    = mode_q ? (eng_val_i == 16'h0000) : 1'b1;
    end
    cnt_d = (state_q == S_RUN) ? cnt_q + CNT_W'(1) : '0;
  end

  assign cks_byte = addr_q + ADDR_BUS'(10);

  // Controller-owned SRAM access: only CLR and WB touch the checksum field
  always_comb begin
    ctl_req = '0;
    if ((state_q == S_CLR) || (state_q == S_WB)) begin
      ctl_req.ce   = 1'b1;
      ctl_req.we   = 1'b1;
      ctl_req.addr = cks_byte >> 2;
      ctl_req.sel  = cks_byte[1] ? 4'b0011 : 4'b1100;
      if (state_q == S_WB)
        ctl_req.data = cks_byte[1] ? DATA_BUS'({16'h0000, cksum_q})
                                   : DATA_BUS'({cksum_q, 16'h0000});
    end
  end

  assign eng_req = '{ce:   eng_sram_ce_i,
                     we:   eng_sram_we_i,
                     addr: eng_sram_addr_i,
                     sel:  eng_sram_sel_i,
                     data: eng_sram_data_i};

  assign sram_req = (state_q == S_RUN) ? eng_req : ctl_req;

  // Output logic
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE) || (state_q == S_ERR);
    ok_o        = (state_q == S_DONE) && ok_q;
    err_o       = (state_q == S_ERR);
    cksum_o     = cksum_q;
    eng_start_o = (state_q == S_RUN);
    eng_addr_o  = (state_q == S_RUN) ? addr_q : '0;
    eng_len_o   = (state_q == S_RUN) ? len_q  : '0;
    sram_ce_o   = sram_req.ce;
    sram_we_o   = sram_req.we;
    sram_addr_o = sram_req.addr;
    sram_sel_o  = sram_req.sel;
    sram_data_o = sram_req.data;
  end

  assign eng_sram_data_o = sram_data_i;

endmodule

// File: tb/tb_cksum_ctrl.sv
// Directed plus randomized bench for cksum_ctrl with a small arithmetic reference model.
module tb_cksum_ctrl;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, mode_i;
  logic [31:0] hdr_addr_i, hdr_len_i;
  logic        busy_o, done_o, ok_o, err_o;
  logic [15:0] cksum_o;
  logic        eng_start_o;
  logic [31:0] eng_addr_o, eng_len_o;
  logic        eng_ready_i;
  logic [15:0] eng_val_i;
  logic        eng_sram_ce_i, eng_sram_we_i;
  logic [31:0] eng_sram_addr_i;
  logic [3:0]  eng_sram_sel_i;
  logic [31:0] eng_sram_data_i, eng_sram_data_o;
  logic        sram_ce_o, sram_we_o;
  logic [31:0] sram_addr_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_data_o, sram_data_i;

  int checks = 0;
  int failures = 0;

  cksum_ctrl #(.TIMEOUT(TMO), .ADDR_BUS(32), .DATA_BUS(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .mode_i(mode_i),
    .hdr_addr_i(hdr_addr_i), .hdr_len_i(hdr_len_i),
    .busy_o(busy_o), .done_o(done_o), .ok_o(ok_o), .err_o(err_o), .cksum_o(cksum_o),
    .eng_start_o(eng_start_o), .eng_addr_o(eng_addr_o), .eng_len_o(eng_len_o),
    .eng_ready_i(eng_ready_i), .eng_val_i(eng_val_i),
    .eng_sram_ce_i(eng_sram_ce_i), .eng_sram_we_i(eng_sram_we_i),
    .eng_sram_addr_i(eng_sram_addr_i), .eng_sram_sel_i(eng_sram_sel_i),
    .eng_sram_data_i(eng_sram_data_i), .eng_sram_data_o(eng_sram_data_o),
    .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_sel_o(sram_sel_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: checksum field sits 10 bytes into the header, big-endian words.
  function automatic logic [31:0] m_word(input logic [31:0] a);
    return (a + 32'd10) / 4;
  endfunction
  function automatic logic [3:0] m_sel(input logic [31:0] a);
    return (((a + 32'd10) % 4) >= 2) ? 4'b0011 : 4'b1100;
  endfunction
  function automatic logic [31:0] m_data(input logic [31:0] a, input logic [15:0] v);
    return (m_sel(a) == 4'b1100) ? ({16'h0, v} * 32'd65536) : {16'h0, v};
  endfunction
  function automatic bit m_bad(input logic [31:0] a, input logic [31:0] l);
    return (a % 2 == 1) || (l < 20) || (l > 60) || (l % 4 != 0);
  endfunction

  task automatic chk_quiet_sram(input string tag);
    chk({tag, "_ce"}, sram_ce_o, 1'b0);
    chk({tag, "_we"}, sram_we_o, 1'b0);
  endtask

  // Starts at a negedge in IDLE; ends at a negedge back in IDLE. dly<0 or >=TMO: engine never readies.
  task automatic run_txn(input bit md, input logic [31:0] a, input logic [31:0] l,
                         input int dly, input logic [15:0] v);
    bit tmo;
    tmo = (dly < 0) || (dly >= TMO);
    chk("idle_busy", busy_o, 1'b0);
    chk_quiet_sram("idle_sram");
    req_i = 1'b1; mode_i = md; hdr_addr_i = a; hdr_len_i = l;
    @(negedge clk);
    req_i = 1'b0; hdr_addr_i = $urandom; hdr_len_i = $urandom;
    if (m_bad(a, l)) begin
      chk("perr_done", done_o, 1'b1);
      chk("perr_err", err_o, 1'b1);
      chk("perr_ok", ok_o, 1'b0);
      chk("perr_ce", sram_ce_o, 1'b0);
      @(negedge clk);
      chk("perr_after_done", done_o, 1'b0);
      return;
    end
    if (!md) begin
      chk("clr_ce", sram_ce_o, 1'b1);
      chk("clr_we", sram_we_o, 1'b1);
      chk("clr_addr", sram_addr_o, m_word(a));
      chk("clr_sel", sram_sel_o, m_sel(a));
      chk("clr_data", sram_data_o, 32'h0);
      chk("clr_start", eng_start_o, 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i < TMO; i++) begin
      eng_sram_ce_i = 1'($urandom); eng_sram_we_i = 1'b0;
      eng_sram_addr_i = $urandom; eng_sram_sel_i = 4'($urandom); eng_sram_data_i = $urandom;
      eng_ready_i = (i == dly);
      eng_val_i = (i == dly) ? v : 16'($urandom);
      #1;
      chk("run_start", eng_start_o, 1'b1);
      chk("run_eaddr", eng_addr_o, a);
      chk("run_elen", eng_len_o, l);
      chk("run_ce", sram_ce_o, eng_sram_ce_i);
      chk("run_addr", sram_addr_o, eng_sram_addr_i);
      chk("run_sel", sram_sel_o, eng_sram_sel_i);
      chk("run_data", sram_data_o, eng_sram_data_i);
      chk("run_we", sram_we_o, 1'b0);
      chk("run_rdata", eng_sram_data_o, sram_data_i);
      chk("run_done", done_o, 1'b0);
      @(negedge clk);
      eng_ready_i = 1'b0;
      eng_sram_ce_i = 1'b1; eng_sram_we_i = 1'b1;
      if (i == dly) break;
    end
    if (tmo) begin
      chk("tmo_done", done_o, 1'b1);
      chk("tmo_err", err_o, 1'b1);
      chk("tmo_ok", ok_o, 1'b0);
      chk("tmo_start", eng_start_o, 1'b0);
      chk_quiet_sram("tmo_sram");
    end else begin
      if (!md) begin
        chk("wb_ce", sram_ce_o, 1'b1);
        chk("wb_we", sram_we_o, 1'b1);
        chk("wb_addr", sram_addr_o, m_word(a));
        chk("wb_sel", sram_sel_o, m_sel(a));
        chk("wb_data", sram_data_o, m_data(a, v));
        chk("wb_done", done_o, 1'b0);
        @(negedge clk);
      end
      chk("done_done", done_o, 1'b1);
      chk("done_ok", ok_o, md ? (v == 16'h0) : 1'b1);
      chk("done_err", err_o, 1'b0);
      chk("done_cksum", cksum_o, v);
      chk_quiet_sram("done_sram");
    end
    @(negedge clk);
    chk("end_done", done_o, 1'b0);
    chk("end_busy", busy_o, 1'b0);
  endtask

  initial begin
    bit          r_md;
    logic [31:0] r_a, r_l;
    int          r_d;
    logic [15:0] r_v;

    rst = 1'b0; req_i = 1'b0; mode_i = 1'b0; hdr_addr_i = '0; hdr_len_i = '0;
    eng_ready_i = 1'b0; eng_val_i = '0;
    eng_sram_ce_i = 1'b1; eng_sram_we_i = 1'b1; eng_sram_addr_i = 32'h55;
    eng_sram_sel_i = 4'hF; eng_sram_data_i = 32'hDEAD_BEEF;
    sram_data_i = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_cksum", cksum_o, 16'h0);
    chk("rst_start", eng_start_o, 1'b0);
    chk("rst_ce", sram_ce_o, 1'b0);
    chk("rst_data", sram_data_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 32'd14, 32'd20, 3, 16'hB861);
    run_txn(1'b0, 32'd16, 32'd20, 0, 16'h1234);
    run_txn(1'b1, 32'd14, 32'd20, 2, 16'h0000);
    run_txn(1'b1, 32'd14, 32'd20, 1, 16'h0001);
    run_txn(1'b0, 32'd15, 32'd20, 0, 16'h0);
    run_txn(1'b0, 32'd14, 32'd18, 0, 16'h0);
    run_txn(1'b1, 32'd14, 32'd64, 0, 16'h0);
    run_txn(1'b0, 32'd14, 32'd22, 0, 16'h0);
    run_txn(1'b0, 32'd14, 32'd20, -1, 16'h0);
    run_txn(1'b1, 32'd14, 32'd20, 5, 16'h0);
    run_txn(1'b0, 32'd18, 32'd60, TMO - 1, 16'hA5A5);

    // req held high: ignored in ERR, re-accepted in the following IDLE cycle
    req_i = 1'b1; mode_i = 1'b0; hdr_addr_i = 32'd15; hdr_len_i = 32'd20;
    @(negedge clk);
    chk("hold_err1", err_o, 1'b1);
    @(negedge clk);
    chk("hold_idle", busy_o, 1'b0);
    @(negedge clk);
    chk("hold_err2", err_o, 1'b1);
    req_i = 1'b0;
    @(negedge clk);
    chk("hold_end", busy_o, 1'b0);

    eng_ready_i = 1'b1;
    @(negedge clk);
    chk("idle_ready_busy", busy_o, 1'b0);
    eng_ready_i = 1'b0;

    // Reset in the middle of RUN
    req_i = 1'b1; mode_i = 1'b0; hdr_addr_i = 32'd14; hdr_len_i = 32'd20;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    eng_sram_ce_i = 1'b1; eng_sram_we_i = 1'b1; eng_sram_data_i = 32'hFFFF_FFFF;
    #1;
    chk("mid_start", eng_start_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    chk("arst_start", eng_start_o, 1'b0);
    chk("arst_eaddr", eng_addr_o, 32'h0);
    chk("arst_elen", eng_len_o, 32'h0);
    chk("arst_cksum", cksum_o, 16'h0);
    chk("arst_ce", sram_ce_o, 1'b0);
    chk("arst_we", sram_we_o, 1'b0);
    chk("arst_data", sram_data_o, 32'h0);
    @(negedge clk);
    chk("arst_hold_done", done_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 32'd14, 32'd20, 2, 16'hBEEF);

    for (int n = 0; n < 24; n++) begin
      r_md = 1'($urandom_range(0, 1));
      r_a  = $urandom_range(0, 400);
      r_l  = $urandom_range(4, 17) * 4 + $urandom_range(0, 1) * $urandom_range(0, 3);
      r_d  = $urandom_range(0, TMO + 1);
      r_v  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      run_txn(r_md, r_a, r_l, r_d, r_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cksum_ctrl.md
# cksum_ctrl

IPv4 header-checksum refresh/verify controller for the packet SRAM. It sequences one `cksum` engine per request: it clears the checksum field, runs the engine over the header, and writes the result back (refresh), or runs the engine and checks for a zero result (verify). It owns the single SRAM port and muxes it between its own accesses and the engine.

## Interface

Parameters:
- `TIMEOUT`, default 1024: maximum cycles spent in RUN waiting for `eng_ready_i`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  start request; sampled only in IDLE.
- `mode_i`  in  1  0 = refresh, 1 = verify; sampled with `req_i`.
- `hdr_addr_i`  in  `ADDR_BUS`  byte address of the IPv4 header (e.g. 14).
- `hdr_len_i`  in  `DATA_BUS`  header length in bytes.
- `busy_o`  out  1  high from acceptance through DONE/ERR.
- `done_o`  out  1  one-cycle completion pulse.
- `ok_o`  out  1  valid with `done_o`: refresh succeeded, or verify result was 0.
- `err_o`  out  1  valid with `done_o`: parameter error or timeout.
- `cksum_o`  out  16  last engine value, held until the next acceptance.
- `eng_start_o`, `eng_addr_o` (`ADDR_BUS`), `eng_len_o` (`DATA_BUS`)  out  engine start and field descriptor.
- `eng_ready_i`  in  1  engine result valid.
- `eng_val_i`  in  16  engine result, already complemented and ready to store.
- `eng_sram_ce_i`, `eng_sram_we_i`, `eng_sram_addr_i`, `eng_sram_sel_i` (4), `eng_sram_data_i`  in  engine SRAM request.
- `eng_sram_data_o`  out  `DATA_BUS`  equals `sram_data_i`.
- `sram_ce_o`, `sram_we_o`, `sram_addr_o` (word address), `sram_sel_o` (4), `sram_data_o`  out  SRAM port.
- `sram_data_i`  in  `DATA_BUS`  SRAM read data.

## Operation

- SRAM words are 32-bit and big-endian. Byte offset 0 maps to bits [31:24]. The checksum field is at byte `C = hdr_addr_i + 10`, word `C>>2`.
  - `C[1]=0`: sel 4'b1100, data in [31:16].
  - `C[1]=1`: sel 4'b0011, data in [15:0].
  - Unselected data bits are driven 0.
- Parameter check on acceptance. `hdr_addr_i[0]=1`, `hdr_len_i<20`, `hdr_len_i>60` or `hdr_len_i[1:0]!=0` go to ERR.
- States:
  - IDLE: `req_i=1` latches addr, len and mode. A bad parameter goes to ERR. Otherwise refresh goes to CLR and verify goes to RUN.
  - CLR: one cycle; writes 16'h0000 to the checksum field (`ce=we=1`). Next state is RUN.
  - RUN: `eng_start_o=1` with `eng_addr_o`/`eng_len_o` driven from the latched values. The SRAM port combinationally follows the `eng_sram_*` inputs.
    - On the first cycle with `eng_ready_i=1`: latch `eng_val_i` into `cksum_o` and drop `eng_start_o`. Refresh goes to WB; verify goes to DONE with `ok = (eng_val_i==0)`.
    - After `TIMEOUT` cycles without ready: go to ERR.
  - WB: one cycle; writes `cksum_o` to the checksum field, then goes to DONE with `ok=1`.
  - DONE: `done_o=1` and `ok_o` valid for one cycle, then IDLE.
  - ERR: `done_o=1`, `err_o=1`, `ok_o=0` for one cycle, then IDLE. No SRAM access is made after the error is detected.
- Outside RUN, the SRAM outputs come from controller registers. They are 0 except during CLR and WB.
- Outside RUN, `eng_start_o=0`.

## Timing

- Reset (async, `rst=0`): state IDLE. All outputs are 0, including `cksum_o` and all `sram_*` outputs. The engine mux selects controller registers. Reset mid-operation aborts immediately with no `done_o`.
- `req_i` accepted at edge k: CLR is at cycle k+1 (refresh), RUN at k+1 (verify) or k+2 (refresh).
- Let edge r be where `eng_ready_i` is first sampled high.
  - Refresh: WB at r+1, `done_o` at r+2.
  - Verify: `done_o` at r+1.
- Parameter error: `done_o`/`err_o` at k+1.
- Timeout: ERR in the cycle after the `TIMEOUT`-th RUN cycle.
- `req_i` in any state other than IDLE (including DONE and ERR) is ignored. `req_i` held high is re-accepted in the IDLE cycle after DONE/ERR.
- `eng_ready_i` outside RUN is ignored.

## Test plan

- Refresh, addr 14, len 20, engine returns 16'hB861.
  - CLR writes word 6, sel 1100, data 32'h0000_0000.
  - RUN shows `eng_addr_o=14`, `eng_len_o=20`.
  - WB writes word 6, sel 1100, data 32'hB861_0000.
  - `done_o` and `ok_o` at r+2; `cksum_o=16'hB861`.
- Refresh, addr 16: checksum at byte 26, so writes go to word 6, sel 0011, data in [15:0].
- Verify on a correct header (engine returns 0): no `sram_we_o` pulse; `done_o=1`, `ok_o=1` at r+1. Engine returns 16'h0001: `ok_o=0`, `err_o=0`.
- Addr 15 (odd), len 20 → `done_o`+`err_o` at k+1, `sram_ce_o` never asserted. Repeat with len 18, 64 and 22.
- Engine never readies, `TIMEOUT=8` → 8 RUN cycles, then `eng_start_o` falls and `err_o` pulses. Next `req_i` is accepted normally.
- Assert `rst=0` during RUN → all outputs 0 asynchronously, no `done_o`. After release, a new refresh completes correctly.
